// File: rtl/memory2_stage_pkg.sv
// Shared types for the memory2 stage: pipeline pass payloads, load width
// encoding and the load-response FSM states.
package cpu_defs;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HELD  = 2'd2,
        DRAIN = 2'd3
    } m2_state_t;

    typedef struct packed {
        logic              is_flush;
        logic              is_wr_rd;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc;
        logic              is_load;
        mem_type_t         load_type;
        logic              is_signed;
        logic [1:0]        addr_lo;
        logic [XLEN-1:0]   ex_out;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic              is_flush;
        logic              is_wr_rd;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   ex_mem_out;
    } memory2_writeback_pass_t;

endpackage

// File: rtl/memory2_stage_load_align.sv
// load_align: extracts the addressed byte/half/word from a word-aligned
// D-cache read and sign- or zero-extends it to XLEN.
// Ports: rdata (read word), load_type, is_signed, lo (byte offset) -> data.
module load_align
    import cpu_defs::*;
(
    input  logic [XLEN-1:0] rdata,
    input  mem_type_t       load_type,
    input  logic            is_signed,
    input  logic [1:0]      lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halves are rejected upstream, so only lo[1] picks the half.
    always_comb begin
        byte_sel = rdata[{lo, 3'b000} +: 8];
        half_sel = rdata[{lo[1], 4'b0000} +: 16];
        data     = rdata;
        case (load_type)
            BYTE:    data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            HALF:    data = {{16{is_signed & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory2_stage.sv
// memory2_stage: registers the memory1 pass, collects the D-cache load
// response, aligns/extends load data and drives the writeback pass.
// Ports: clk, rst (async active-high), is_stall, is_flush, pass_in,
//        dc_rvalid, dc_rdata -> stall_req, pass_out, fwd_valid, fwd_rd,
//        fwd_data, wait_timeout (sticky watchdog).
module memory2_stage
    import cpu_defs::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         is_stall,
    input  logic                                         is_flush,
    input  logic [$bits(memory1_memory2_pass_t)-1:0]     pass_in,
    input  logic                                         dc_rvalid,
    input  logic [XLEN-1:0]                              dc_rdata,
    output logic                                         stall_req,
    output logic [$bits(memory2_writeback_pass_t)-1:0]   pass_out,
    output logic                                         fwd_valid,
    output logic [REG_AW-1:0]                            fwd_rd,
    output logic [XLEN-1:0]                              fwd_data,
    output logic                                         wait_timeout
);

    localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

    memory1_memory2_pass_t   pass_in_r;
    memory2_writeback_pass_t pout;
    m2_state_t               state, state_n;
    logic [XLEN-1:0]         rbuf;
    logic                    rbuf_load;
    logic [WCNT_W-1:0]       wcnt;
    logic                    m2_kill;
    logic                    ld;
    logic [XLEN-1:0]         rdata;
    logic [XLEN-1:0]         aligned;

    // Input pipeline register; reset state is a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_in_r          <= '0;
            pass_in_r.is_flush <= 1'b1;
        end else if (!is_stall) begin
            pass_in_r <= memory1_memory2_pass_t'(pass_in);
        end
    end

    assign m2_kill = pass_in_r.is_flush | is_flush;
    assign ld      = pass_in_r.is_load & ~m2_kill;

    // FSM state register and load-data buffer for responses caught during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rbuf  <= '0;
        end else begin
            state <= state_n;
            if (rbuf_load) rbuf <= dc_rdata;
        end
    end

    // Next-state logic; a response arriving after a flush is drained in DRAIN.
    always_comb begin
        state_n   = state;
        rbuf_load = 1'b0;
        case (state)
            IDLE: begin
                if (ld && !dc_rvalid) begin
                    state_n = WAIT;
                end else if (ld && dc_rvalid && is_stall) begin
                    state_n   = HELD;
                    rbuf_load = 1'b1;
                end
            end
            WAIT: begin
                if (dc_rvalid) begin
                    if (is_flush) begin
                        state_n = IDLE;
                    end else if (is_stall) begin
                        state_n   = HELD;
                        rbuf_load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (is_flush) begin
                    state_n = DRAIN;
                end
            end
            HELD: begin
                if (is_flush || !is_stall) state_n = IDLE;
            end
            DRAIN: begin
                if (dc_rvalid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A response seen in DRAIN belongs to the flushed load, so it never satisfies ld.
    assign stall_req = ld & ~(dc_rvalid & (state != DRAIN)) & (state != HELD);
    assign rdata     = (state == HELD) ? rbuf : dc_rdata;

    load_align u_load_align (
        .rdata     (rdata),
        .load_type (pass_in_r.load_type),
        .is_signed (pass_in_r.is_signed),
        .lo        (pass_in_r.addr_lo),
        .data      (aligned)
    );

    // Writeback pass; a bubble is sent while load data is outstanding.
    always_comb begin
        pout            = '0;
        pout.is_flush   = m2_kill | stall_req;
        pout.is_wr_rd   = pass_in_r.is_wr_rd;
        pout.rd         = pass_in_r.rd;
        pout.pc         = pass_in_r.pc;
        pout.ex_mem_out = ld ? aligned : pass_in_r.ex_out;
    end

    assign pass_out  = pout;
    assign fwd_valid = ~pout.is_flush & pout.is_wr_rd;
    assign fwd_rd    = pout.rd;
    assign fwd_data  = pout.ex_mem_out;

    // Watchdog: counts consecutive cycles spent waiting on the D-cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt         <= '0;
            wait_timeout <= 1'b0;
        end else begin
            if (state == WAIT || state == DRAIN) begin
                if (wcnt != WCNT_W'(MAX_WAIT)) wcnt <= wcnt + WCNT_W'(1);
            end else begin
                wcnt <= '0;
            end
            if (wcnt == WCNT_W'(MAX_WAIT)) wait_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory2_stage.sv
// Directed bench for memory2_stage with hand-computed expected values.
module tb_memory2_stage;
    import cpu_defs::*;

    logic                                       clk;
    logic                                       rst;
    logic                                       is_stall;
    logic                                       is_flush;
    memory1_memory2_pass_t                      pass_in;
    logic                                       dc_rvalid;
    logic [31:0]                                dc_rdata;
    logic                                       stall_req;
    logic [$bits(memory2_writeback_pass_t)-1:0] pass_out;
    logic                                       fwd_valid;
    logic [4:0]                                 fwd_rd;
    logic [31:0]                                fwd_data;
    logic                                       wait_timeout;
    memory2_writeback_pass_t                    po;

    int total = 0;
    int bad   = 0;

    memory2_stage #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .is_stall     (is_stall),
        .is_flush     (is_flush),
        .pass_in      (pass_in),
        .dc_rvalid    (dc_rvalid),
        .dc_rdata     (dc_rdata),
        .stall_req    (stall_req),
        .pass_out     (pass_out),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .wait_timeout (wait_timeout)
    );

    assign po = memory2_writeback_pass_t'(pass_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic memory1_memory2_pass_t mk(input logic is_ld, input mem_type_t t,
                                                 input logic sgn, input logic [1:0] lo,
                                                 input logic [31:0] ex, input logic [4:0] rd);
        memory1_memory2_pass_t p;
        p           = '0;
        p.is_wr_rd  = 1'b1;
        p.rd        = rd;
        p.pc        = 32'h0000_0100;
        p.is_load   = is_ld;
        p.load_type = t;
        p.is_signed = sgn;
        p.addr_lo   = lo;
        p.ex_out    = ex;
        return p;
    endfunction

    function automatic memory1_memory2_pass_t bubble();
        memory1_memory2_pass_t p;
        p          = '0;
        p.is_flush = 1'b1;
        return p;
    endfunction

    // Load whose response arrives in the same cycle it reaches this stage.
    task automatic load_hit(input string tag, input mem_type_t t, input logic sgn,
                            input logic [1:0] lo, input logic [31:0] word, input logic [31:0] exp);
        pass_in = mk(1'b1, t, sgn, lo, 32'h0, 5'd5);
        tick();
        pass_in   = bubble();
        dc_rvalid = 1'b1;
        dc_rdata  = word;
        #1;
        chk({tag, "_data"}, po.ex_mem_out, exp);
        chk({tag, "_stall"}, 32'(stall_req), 32'd0);
        chk({tag, "_fwdv"}, 32'(fwd_valid), 32'd1);
        tick();
        dc_rvalid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        is_stall  = 1'b0;
        is_flush  = 1'b0;
        dc_rvalid = 1'b0;
        dc_rdata  = '0;
        pass_in   = bubble();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_flush", 32'(po.is_flush), 32'd1);
        chk("rst_fwdv", 32'(fwd_valid), 32'd0);
        chk("rst_tmo", 32'(wait_timeout), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // Same-cycle loads across widths, offsets and extension modes.
        load_hit("lb_s3", BYTE, 1'b1, 2'd3, 32'h8012_3456, 32'hFFFF_FF80);
        load_hit("lh_s0", HALF, 1'b1, 2'd0, 32'h1234_8001, 32'hFFFF_8001);
        load_hit("lbu_1", BYTE, 1'b0, 2'd1, 32'h0000_AB00, 32'h0000_00AB);
        load_hit("lh_s2", HALF, 1'b1, 2'd2, 32'h7FFF_0000, 32'h0000_7FFF);
        load_hit("lw_0",  WORD, 1'b0, 2'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
        chk("lb_fwdrd", 32'(dut.state), 32'(IDLE));

        // LHU with response three cycles late.
        pass_in = mk(1'b1, HALF, 1'b0, 2'd2, 32'h0, 5'd6);
        tick();
        pass_in  = bubble();
        is_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("lhu_stall%0d", i), 32'(stall_req), 32'd1);
            chk($sformatf("lhu_bub%0d", i), 32'(po.is_flush), 32'd1);
            chk($sformatf("lhu_fwdv%0d", i), 32'(fwd_valid), 32'd0);
            tick();
        end
        is_stall  = 1'b0;
        dc_rvalid = 1'b1;
        dc_rdata  = 32'hBEEF_0000;
        #1;
        chk("lhu_stall_end", 32'(stall_req), 32'd0);
        chk("lhu_data", po.ex_mem_out, 32'h0000_BEEF);
        chk("lhu_fwd", fwd_data, 32'h0000_BEEF);
        chk("lhu_fwdrd", 32'(fwd_rd), 32'd6);
        tick();
        dc_rvalid = 1'b0;
        #1;
        chk("lhu_idle", 32'(dut.state), 32'(IDLE));
        chk("lhu_tmo", 32'(wait_timeout), 32'd0);

        // Response arrives in WAIT under stall -> HELD, data from rbuf.
        pass_in = mk(1'b1, WORD, 1'b0, 2'd0, 32'h0, 5'd7);
        tick();
        is_stall = 1'b1;
        #1;
        chk("held_stall", 32'(stall_req), 32'd1);
        tick();
        dc_rvalid = 1'b1;
        dc_rdata  = 32'hCAFE_BABE;
        #1;
        chk("held_stall0", 32'(stall_req), 32'd0);
        chk("held_d0", po.ex_mem_out, 32'hCAFE_BABE);
        tick();
        dc_rvalid = 1'b0;
        dc_rdata  = 32'h1111_1111;
        #1;
        chk("held_state", 32'(dut.state), 32'(HELD));
        chk("held_d1", po.ex_mem_out, 32'hCAFE_BABE);
        chk("held_stall1", 32'(stall_req), 32'd0);
        tick();
        is_stall = 1'b0;
        pass_in  = bubble();
        #1;
        chk("held_d2", po.ex_mem_out, 32'hCAFE_BABE);
        chk("held_state2", 32'(dut.state), 32'(HELD));
        tick();
        chk("held_idle", 32'(dut.state), 32'(IDLE));

        // Flush in WAIT, new LW arrives before the stale response.
        pass_in = mk(1'b1, WORD, 1'b0, 2'd0, 32'h0, 5'd8);
        tick();
        is_stall = 1'b1;
        tick();
        is_stall = 1'b0;
        is_flush = 1'b1;
        pass_in  = mk(1'b1, WORD, 1'b0, 2'd0, 32'h0, 5'd9);
        #1;
        chk("fl_bub", 32'(po.is_flush), 32'd1);
        chk("fl_fwdv", 32'(fwd_valid), 32'd0);
        tick();
        is_flush  = 1'b0;
        is_stall  = 1'b1;
        dc_rvalid = 1'b1;
        dc_rdata  = 32'h0000_DEAD;
        #1;
        chk("dr_state", 32'(dut.state), 32'(DRAIN));
        chk("dr_stall", 32'(stall_req), 32'd1);
        chk("dr_fwdv", 32'(fwd_valid), 32'd0);
        tick();
        is_stall = 1'b0;
        dc_rdata = 32'h0000_1234;
        pass_in  = bubble();
        #1;
        chk("dr_stall2", 32'(stall_req), 32'd0);
        chk("dr_data", po.ex_mem_out, 32'h0000_1234);
        chk("dr_fwdrd", 32'(fwd_rd), 32'd9);
        chk("dr_fwdv2", 32'(fwd_valid), 32'd1);
        tick();
        dc_rvalid = 1'b0;

        // Non-load ALU result passes straight through.
        pass_in = mk(1'b0, WORD, 1'b0, 2'd0, 32'd7, 5'd10);
        tick();
        pass_in = bubble();
        #1;
        chk("alu_data", po.ex_mem_out, 32'd7);
        chk("alu_stall", 32'(stall_req), 32'd0);
        chk("alu_fwdv", 32'(fwd_valid), 32'd1);
        tick();
        chk("alu_idle", 32'(dut.state), 32'(IDLE));

        // Watchdog: withhold the response for six cycles.
        pass_in = mk(1'b1, WORD, 1'b0, 2'd0, 32'h0, 5'd11);
        tick();
        is_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("wd_stall%0d", i), 32'(stall_req), 32'd1);
            if (i == 0) chk("wd_tmo_pre", 32'(wait_timeout), 32'd0);
            tick();
        end
        chk("wd_tmo", 32'(wait_timeout), 32'd1);
        is_stall  = 1'b0;
        dc_rvalid = 1'b1;
        dc_rdata  = 32'h0000_0055;
        pass_in   = bubble();
        #1;
        chk("wd_data", po.ex_mem_out, 32'h0000_0055);
        tick();
        dc_rvalid = 1'b0;
        #1;
        chk("wd_sticky", 32'(wait_timeout), 32'd1);

        // Reset asserted while waiting on a load.
        pass_in = mk(1'b1, WORD, 1'b0, 2'd0, 32'h0, 5'd12);
        tick();
        is_stall = 1'b1;
        tick();
        chk("rm_wait", 32'(dut.state), 32'(WAIT));
        rst = 1'b1;
        #1;
        chk("rm_stall", 32'(stall_req), 32'd0);
        chk("rm_tmo", 32'(wait_timeout), 32'd0);
        chk("rm_state", 32'(dut.state), 32'(IDLE));
        chk("rm_flush", 32'(po.is_flush), 32'd1);
        is_stall = 1'b0;
        pass_in  = bubble();
        tick();
        rst       = 1'b0;
        dc_rvalid = 1'b1;
        dc_rdata  = 32'h0000_BAD0;
        #1;
        chk("rm_stale_stall", 32'(stall_req), 32'd0);
        tick();
        dc_rvalid = 1'b0;
        chk("rm_stale_state", 32'(dut.state), 32'(IDLE));
        chk("rm_stale_fwdv", 32'(fwd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
